// File: rtl/spdif_pkg.sv
// Shared types for the S/PDIF receiver back end: sample width, channel
// encoding of lrck and the stereo pair layout used by the pair FIFO.
package spdif_pkg;

  localparam int SAMPLE_W = 24;
  localparam int PAIR_W   = 2 * SAMPLE_W;

  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;

  typedef enum logic {
    WAIT_L = 1'b0,
    HAVE_L = 1'b1
  } pair_state_e;

endpackage

// File: rtl/spdif_pair_fifo.sv
// Synchronous first-word-fall-through FIFO of stereo pairs. A push while full
// is only accepted when the head leaves on the same edge; otherwise it is dropped.
module spdif_pair_fifo
  import spdif_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [PAIR_W-1:0]        din,
  input  logic                     pop,
  output logic [PAIR_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [PAIR_W-1:0] mem [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dropped = push && !push_ok;
  assign level   = count;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spdif_stereo_buffer.sv
// Pairs left/right subframes from the S/PDIF receiver into stereo samples,
// queues them and hands them to the mixer; orphans and overflow are counted.
module spdif_stereo_buffer
  import spdif_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_W-1:0]     data_i,
  input  logic                    ack_i,
  input  logic                    lrck_i,
  input  logic                    locked_i,
  output logic [SAMPLE_W-1:0]     left_o,
  output logic [SAMPLE_W-1:0]     right_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic [CNT_W-1:0]        drop_cnt_o,
  output logic [CNT_W-1:0]        sync_err_cnt_o,
  output logic                    pair_state_o
);

  // Handshake: the head pair on left_o/right_o is transferred on every rising
  // edge where valid_o && ready_i; valid_o never drops without a transfer and
  // ready_i has no effect while valid_o is low.

  pair_state_e         state;
  logic [SAMPLE_W-1:0] held_left;
  logic [CNT_W-1:0]    drop_cnt;
  logic [CNT_W-1:0]    sync_err_cnt;

  logic                ack_live;
  logic                push;
  logic                sync_err;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_dropped;
  logic [PAIR_W-1:0]   fifo_dout;
  pair_t               push_pair;
  pair_t               head;

  assign ack_live = locked_i && ack_i;
  assign push     = ack_live && (state == HAVE_L) && (lrck_i == LRCK_RIGHT);
  assign sync_err = ack_live && (((state == WAIT_L) && (lrck_i == LRCK_RIGHT)) ||
                                 ((state == HAVE_L) && (lrck_i == LRCK_LEFT)));

  assign push_pair.left  = held_left;
  assign push_pair.right = data_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WAIT_L;
      held_left <= '0;
    end else if (!locked_i) begin
      // Loss of lock abandons a half-built pair silently.
      state     <= WAIT_L;
      held_left <= '0;
    end else if (ack_i) begin
      case (state)
        WAIT_L: begin
          if (lrck_i == LRCK_LEFT) begin
            held_left <= data_i;
            state     <= HAVE_L;
          end
        end
        HAVE_L: begin
          if (lrck_i == LRCK_LEFT) begin
            held_left <= data_i;
          end else begin
            state <= WAIT_L;
          end
        end
        default: state <= WAIT_L;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt     <= '0;
      sync_err_cnt <= '0;
    end else begin
      if (fifo_dropped && (drop_cnt != '1))  drop_cnt     <= drop_cnt + CNT_W'(1);
      if (sync_err && (sync_err_cnt != '1))  sync_err_cnt <= sync_err_cnt + CNT_W'(1);
    end
  end

  spdif_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .din     (push_pair),
    .pop     (ready_i),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level_o),
    .dropped (fifo_dropped)
  );

  assign head    = fifo_dout;
  assign valid_o = !fifo_empty;
  assign left_o  = valid_o ? head.left  : '0;
  assign right_o = valid_o ? head.right : '0;

  assign drop_cnt_o     = drop_cnt;
  assign sync_err_cnt_o = sync_err_cnt;
  assign pair_state_o   = (state == HAVE_L);

endmodule

// File: tb/tb_spdif_stereo_buffer.sv
// Directed bench for spdif_stereo_buffer: pairing, orphans, overflow,
// full-with-pop, unlock and asynchronous reset.
module tb_spdif_stereo_buffer;

  logic        clk;
  logic        rst;
  logic [23:0] data_i;
  logic        ack_i;
  logic        lrck_i;
  logic        locked_i;
  logic [23:0] left_o;
  logic [23:0] right_o;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  level_o;
  logic [7:0]  drop_cnt_o;
  logic [7:0]  sync_err_cnt_o;
  logic        pair_state_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [47:0] exp_q[$];
  logic [47:0] exp_pair;

  spdif_stereo_buffer #(
    .DEPTH (8),
    .CNT_W (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_i         (data_i),
    .ack_i          (ack_i),
    .lrck_i         (lrck_i),
    .locked_i       (locked_i),
    .left_o         (left_o),
    .right_o        (right_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .level_o        (level_o),
    .drop_cnt_o     (drop_cnt_o),
    .sync_err_cnt_o (sync_err_cnt_o),
    .pair_state_o   (pair_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // driver tasks: inputs change on the falling edge, results are read on the
  // following falling edge, after the rising edge has sampled them
  task automatic send(input logic lr, input logic [23:0] d);
    @(negedge clk);
    ack_i  = 1'b1;
    lrck_i = lr;
    data_i = d;
    @(negedge clk);
    ack_i  = 1'b0;
  endtask

  task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
    @(negedge clk);
    ack_i = 1'b1; lrck_i = 1'b0; data_i = l;
    @(negedge clk);
    ack_i = 1'b1; lrck_i = 1'b1; data_i = r;
    @(negedge clk);
    ack_i = 1'b0;
  endtask

  task automatic check_head(input string tag);
    exp_pair = exp_q.pop_front();
    check({tag, "_valid"}, 48'(valid_o), 48'd1);
    check({tag, "_left"},  48'(left_o),  48'(exp_pair[47:24]));
    check({tag, "_right"}, 48'(right_o), 48'(exp_pair[23:0]));
  endtask

  initial begin
    rst = 1'b0; data_i = '0; ack_i = 1'b0; lrck_i = 1'b0;
    locked_i = 1'b1; ready_i = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_valid", 48'(valid_o), 48'd0);
    check("rst_left",  48'(left_o),  48'd0);
    check("rst_right", 48'(right_o), 48'd0);
    check("rst_level", 48'(level_o), 48'd0);
    check("rst_drop",  48'(drop_cnt_o), 48'd0);
    check("rst_sync",  48'(sync_err_cnt_o), 48'd0);
    check("rst_state", 48'(pair_state_o), 48'd0);
    rst = 1'b1;

    // basic pairing with a consumer that is always ready
    ready_i = 1'b1;
    send(1'b0, 24'h123456);
    check("basic_have_l", 48'(pair_state_o), 48'd1);
    send(1'b1, 24'hABCDEF);
    check("basic_valid", 48'(valid_o), 48'd1);
    check("basic_left",  48'(left_o),  48'h123456);
    check("basic_right", 48'(right_o), 48'hABCDEF);
    check("basic_level", 48'(level_o), 48'd1);
    @(negedge clk);
    check("basic_valid_gone", 48'(valid_o), 48'd0);
    check("basic_left_zero",  48'(left_o),  48'd0);
    check("basic_drop", 48'(drop_cnt_o), 48'd0);
    check("basic_sync", 48'(sync_err_cnt_o), 48'd0);

    // orphans: R, L, L, R -> two sync errors, pair carries the second L
    ready_i = 1'b0;
    send(1'b1, 24'h000011);
    send(1'b0, 24'h000022);
    send(1'b0, 24'h000033);
    send(1'b1, 24'h000044);
    check("orph_sync",  48'(sync_err_cnt_o), 48'd2);
    check("orph_level", 48'(level_o), 48'd1);
    exp_q.push_back({24'h000033, 24'h000044});
    check_head("orph");
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("orph_drained", 48'(valid_o), 48'd0);

    // overflow: ten back-to-back pairs into an eight-deep FIFO
    for (int i = 1; i <= 10; i++) begin
      send_pair(24'h100000 + 24'(i), 24'h200000 + 24'(i));
      if (i <= 8) exp_q.push_back({24'h100000 + 24'(i), 24'h200000 + 24'(i)});
    end
    check("ovf_level", 48'(level_o), 48'd8);
    check("ovf_drop",  48'(drop_cnt_o), 48'd2);
    check("ovf_sync",  48'(sync_err_cnt_o), 48'd2);

    // full with simultaneous pop: push accepted, level and drop count unchanged
    send(1'b0, 24'h10000B);
    check("fullpop_head", 48'(left_o), 48'h100001);
    @(negedge clk);
    ack_i = 1'b1; lrck_i = 1'b1; data_i = 24'h20000B; ready_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({24'h10000B, 24'h20000B});
    check("fullpop_level", 48'(level_o), 48'd8);
    check("fullpop_drop",  48'(drop_cnt_o), 48'd2);

    // drain in order: pairs 2..8 then the pair accepted while full
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("drain%0d", i));
      @(negedge clk);
    end
    check("drain_empty", 48'(valid_o), 48'd0);
    check("drain_level", 48'(level_o), 48'd0);

    // unlock mid-pair: held left discarded, ack during unlock ignored
    send(1'b0, 24'h555555);
    @(negedge clk);
    locked_i = 1'b0;
    ack_i = 1'b1; lrck_i = 1'b1; data_i = 24'h777777;
    @(negedge clk);
    ack_i = 1'b0; locked_i = 1'b1;
    check("unlock_state", 48'(pair_state_o), 48'd0);
    check("unlock_sync_kept", 48'(sync_err_cnt_o), 48'd2);
    check("unlock_nopush", 48'(valid_o), 48'd0);
    send(1'b1, 24'h666666);
    check("unlock_orphan_r", 48'(sync_err_cnt_o), 48'd3);
    check("unlock_valid", 48'(valid_o), 48'd0);
    check("unlock_level", 48'(level_o), 48'd0);

    // asynchronous reset with three pairs queued
    ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) send_pair(24'hA00000 + 24'(i), 24'hB00000 + 24'(i));
    check("arst_pre_level", 48'(level_o), 48'd3);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 48'(valid_o), 48'd0);
    check("arst_level", 48'(level_o), 48'd0);
    check("arst_left",  48'(left_o),  48'd0);
    check("arst_drop",  48'(drop_cnt_o), 48'd0);
    check("arst_sync",  48'(sync_err_cnt_o), 48'd0);
    @(negedge clk);
    rst = 1'b1;
    send_pair(24'h0BEEF1, 24'h0BEEF2);
    check("post_level", 48'(level_o), 48'd1);
    exp_q.delete();
    exp_q.push_back({24'h0BEEF1, 24'h0BEEF2});
    check_head("post");
    check("post_sync", 48'(sync_err_cnt_o), 48'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spdif_stereo_buffer.md
# spdif_stereo_buffer

Downstream stage of the S/PDIF receiver. It consumes the receiver's per-subframe sample strobe (24-bit data, ack pulse, lrck, locked) and pairs left and right subframes into stereo samples. Completed pairs go into a small FIFO. The pairs leave through a valid/ready handshake toward the mixer datapath. Orphaned subframes and overflow are counted rather than propagated.

## Interface
- `DEPTH`, 8: FIFO depth in stereo pairs. Power of two, ≥2.
- `CNT_W`, 8: width of the saturating error counters.
- `clk` in 1: the single clock. One clock; reset is asynchronous and active-low.
- `rst` in 1: asynchronous, active-low reset.
- `data_i` in 24: subframe audio sample. Valid only in the `ack_i` cycle.
- `ack_i` in 1: one-cycle strobe, one new subframe sample.
- `lrck_i` in 1: channel of the `ack_i` sample. 0 = left (B/M preamble), 1 = right (W preamble).
- `locked_i` in 1: receiver lock status.
- `left_o` out 24: head-of-FIFO left sample. 0 when `valid_o`=0.
- `right_o` out 24: head-of-FIFO right sample. 0 when `valid_o`=0.
- `valid_o` out 1: FIFO non-empty.
- `ready_i` in 1: consumer accepts the head pair when `valid_o`&&`ready_i`.
- `level_o` out log2(DEPTH)+1: current FIFO occupancy.
- `drop_cnt_o` out CNT_W: pairs discarded because the FIFO was full. Saturating.
- `sync_err_cnt_o` out CNT_W: orphan subframes discarded. Saturating.

## Operation
- Pairing FSM states: `WAIT_L` and `HAVE_L`. Reset state is `WAIT_L`, with the held left register cleared to 0.
- `WAIT_L`:
  - `ack_i`&&`lrck_i`=0: latch `data_i` as held left, go to `HAVE_L`.
  - `ack_i`&&`lrck_i`=1: orphan right. Discard it, `sync_err_cnt`++, stay in `WAIT_L`.
- `HAVE_L`:
  - `ack_i`&&`lrck_i`=1: push {held left, `data_i`}, go to `WAIT_L`.
  - `ack_i`&&`lrck_i`=0: orphan left. Overwrite held left, `sync_err_cnt`++, stay in `HAVE_L`.
- `locked_i`=0 in any cycle: force `WAIT_L` and discard the held left without counting it. An `ack_i` in the same cycle is ignored. FIFO contents are kept.
- Push with FIFO full and no pop in the same cycle: drop the pair, `drop_cnt`++.
- Push with FIFO full and a pop in the same cycle: accept the push, `level_o` unchanged.
- Push and pop in the same cycle when not full: `level_o` unchanged, order preserved.
- Pop only when `valid_o`&&`ready_i`. `ready_i` is ignored while empty.
- Counters saturate at 2^CNT_W−1. They are cleared only by `rst`.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a separate (log2(DEPTH)+1)-bit count.

## Timing
- Reset: all outputs are 0 (`valid_o`, `left_o`, `right_o`, `level_o`, both counters). The FSM is in `WAIT_L`.
- Write latency:
  - The pair is written on the edge that samples the right `ack_i`.
  - When the FIFO was empty, `valid_o` goes to 1 in the next cycle with the pair on `left_o`/`right_o`.
- Read is first-word-fall-through. After the edge with `valid_o`&&`ready_i`, the next pair (or 0/`valid_o`=0) is presented.
- Counters and `level_o` update on the same edge as the event that causes them.
- Back-to-back `ack_i` in consecutive cycles must be handled, even though the receiver never produces them.
- `rst` asserted mid-operation empties the FIFO asynchronously and returns the FSM to `WAIT_L`. Deassertion is synchronised externally.

## Structure
- Shared package `spdif_pkg`:
  - `SAMPLE_W`=24.
  - `LRCK_LEFT`=1'b0 and `LRCK_RIGHT`=1'b1.
  - Pair typedef {left, right}.
- One sub-module, `spdif_pair_fifo`:
  - Parameterised sync FIFO of 48-bit entries: push, pop, full, empty, level, first-word-fall-through output.
  - Owns the full-with-simultaneous-pop rule.
- The top level holds the pairing FSM, held-left register, error counters and output zero-gating.

## Test plan
- **Basic pairing:** L=0x123456 then R=0xABCDEF acks, `ready_i`=1 → one pair out (0x123456, 0xABCDEF), `valid_o` high for exactly 1 cycle, counters 0.
- **Orphans:** sequence R, L, L, R → `sync_err_cnt_o`=2, single output pair carries the second L value.
- **Overflow:** `ready_i`=0, push 10 pairs with DEPTH=8 → `level_o`=8, `drop_cnt_o`=2. Drain yields pairs 1–8 in order.
- **Full with simultaneous pop:** FIFO full, push and pop in the same cycle → `level_o` stays 8, `drop_cnt_o` unchanged.
- **Unlock mid-pair:** L acked, `locked_i` drops, then R acked after relock → no pair pushed, `sync_err_cnt_o`=1 (orphan R).
- **Async reset mid-stream:** `rst`=0 with 3 pairs queued → `valid_o`, `level_o` and counters read 0 immediately. A fresh L/R after release produces one pair.
